// File: rtl/depth_stream_packetizer.sv
// Depth/confidence pixel stream to byte stream packetizer with a per-frame sync header.
// Optional CRC-8 frame trailer is built when DEPTH_PACKET_CRC_EN is defined.
module depth_stream_packetizer #(
   parameter int          IMAGE_WIDTH  = 640,
   parameter int          IMAGE_HEIGHT = 480,
   parameter int          FIFO_DEPTH   = 1024,
   parameter logic [15:0] SYNC_WORD    = 16'hA55A
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] z_i,
   input  logic [15:0] c_i,
   input  logic [15:0] col_i,
   input  logic [15:0] row_i,
   input  logic        valid_i,
   output logic [7:0]  byte_o,
   output logic        byte_valid_o,
   input  logic        byte_ready_i,
   output logic [15:0] frame_count_o,
   output logic        overflow_o,
   output logic [15:0] pixels_dropped_o
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [15:0] LP_W    = 16'(IMAGE_WIDTH);
   localparam logic [15:0] LP_H    = 16'(IMAGE_HEIGHT);
   localparam logic [15:0] LP_WM1  = 16'(IMAGE_WIDTH - 1);
   localparam logic [15:0] LP_HM1  = 16'(IMAGE_HEIGHT - 1);
   localparam logic [AW:0] LP_ONE  = {{AW{1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_HDR3, S_ZHI, S_ZLO, S_CHI, S_CLO
`ifdef DEPTH_PACKET_CRC_EN
      , S_CRC
`endif
   } state_t;

   logic [15:0] r_z, r_c, r_col, r_row;
   logic        r_valid;
   logic [33:0] r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic [33:0] r_pix;
   logic [15:0] r_frame_cnt;
   logic        r_ovf;
   logic [15:0] r_drops;
   state_t      r_state, w_state_nxt;

   logic        w_in_range, w_empty, w_full, w_push, w_drop, w_pop, w_hs;
   logic [33:0] w_head, w_entry;
   state_t      w_head_state;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_z     <= '0;
         r_c     <= '0;
         r_col   <= '0;
         r_row   <= '0;
      end else begin
         r_valid <= valid_i;
         r_z     <= z_i;
         r_c     <= c_i;
         r_col   <= col_i;
         r_row   <= row_i;
      end
   end

   assign w_in_range = (r_col < LP_W) && (r_row < LP_H);
   assign w_entry    = {(r_col == 16'd0) && (r_row == 16'd0),
                        (r_col == LP_WM1) && (r_row == LP_HM1), r_z, r_c};
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   // Full is judged on pre-pop occupancy, so a same-cycle pop never rescues a write.
   assign w_push     = r_valid && w_in_range && !w_full;
   assign w_drop     = r_valid && w_in_range && w_full;
   assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
   assign w_head_state = w_head[33] ? S_HDR0 : S_ZHI;
   assign w_hs       = byte_valid_o && byte_ready_i;

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_ovf    <= 1'b0;
         r_drops  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + LP_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_ONE;
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_pix       <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) r_pix <= w_head;
         if (w_hs && (r_state == S_HDR3)) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = w_head_state;
         end
         S_HDR0: if (w_hs) w_state_nxt = S_HDR1;
         S_HDR1: if (w_hs) w_state_nxt = S_HDR2;
         S_HDR2: if (w_hs) w_state_nxt = S_HDR3;
         S_HDR3: if (w_hs) w_state_nxt = S_ZHI;
         S_ZHI:  if (w_hs) w_state_nxt = S_ZLO;
         S_ZLO:  if (w_hs) w_state_nxt = S_CHI;
         S_CHI:  if (w_hs) w_state_nxt = S_CLO;
         S_CLO: if (w_hs) begin
`ifdef DEPTH_PACKET_CRC_EN
            if (r_pix[32]) w_state_nxt = S_CRC;
            else
`endif
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = w_head_state;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
`ifdef DEPTH_PACKET_CRC_EN
         S_CRC: if (w_hs) begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = w_head_state;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

`ifdef DEPTH_PACKET_CRC_EN
   logic [7:0] r_crc;

   function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] v;
      v = crc ^ data;
      for (int i = 0; i < 8; i++) v = v[7] ? ((v << 1) ^ 8'h07) : (v << 1);
      return v;
   endfunction

   // Popping a start-of-frame pixel means HDR0 is next: restart coverage there.
   always_ff @(posedge clk_i) begin
      if (rst_i)                     r_crc <= '0;
      else if (w_pop && w_head[33])  r_crc <= '0;
      else if (w_hs && (r_state != S_CRC)) r_crc <= f_crc8(r_crc, byte_o);
   end
`else
   logic w_unused_eof;
   assign w_unused_eof = r_pix[32];
`endif

   always_comb begin
      byte_o       = 8'h00;
      byte_valid_o = 1'b1;
      case (r_state)
         S_HDR0:  byte_o = SYNC_WORD[15:8];
         S_HDR1:  byte_o = SYNC_WORD[7:0];
         S_HDR2:  byte_o = r_frame_cnt[15:8];
         S_HDR3:  byte_o = r_frame_cnt[7:0];
         S_ZHI:   byte_o = r_pix[31:24];
         S_ZLO:   byte_o = r_pix[23:16];
         S_CHI:   byte_o = r_pix[15:8];
         S_CLO:   byte_o = r_pix[7:0];
`ifdef DEPTH_PACKET_CRC_EN
         S_CRC:   byte_o = r_crc;
`endif
         default: byte_valid_o = 1'b0;
      endcase
   end

   assign frame_count_o    = r_frame_cnt;
   assign overflow_o       = r_ovf;
   assign pixels_dropped_o = r_drops;

endmodule

// File: tb/tb_depth_stream_packetizer.sv
// Randomized bench for depth_stream_packetizer against a byte-queue reference model.
module tb_depth_stream_packetizer;

   localparam int W = 2;
   localparam int H = 1;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [15:0] z_i, c_i, col_i, row_i;
   logic        valid_i;
   logic [7:0]  byte_o;
   logic        byte_valid_o;
   logic        byte_ready_i;
   logic [15:0] frame_count_o;
   logic        overflow_o;
   logic [15:0] pixels_dropped_o;

   always #5 clk_i = ~clk_i;

   depth_stream_packetizer #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .FIFO_DEPTH(4), .SYNC_WORD(16'hA55A)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .z_i(z_i), .c_i(c_i), .col_i(col_i), .row_i(row_i),
      .valid_i(valid_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
      .byte_ready_i(byte_ready_i), .frame_count_o(frame_count_o),
      .overflow_o(overflow_o), .pixels_dropped_o(pixels_dropped_o)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model: the exact byte sequence the link should carry.
   logic [7:0]  q[$];
   logic [15:0] m_fc = 0;
   logic [7:0]  m_crc = 0;
   int          m_drops = 0;
   logic        m_ovf = 0;

   function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic [7:0] b);
      logic [7:0] v;
      v = crc ^ b;
      for (int i = 0; i < 8; i++) v = v[7] ? ((v << 1) ^ 8'h07) : (v << 1);
      return v;
   endfunction

   task automatic m_put(input logic [7:0] b);
      q.push_back(b);
      m_crc = crc_step(m_crc, b);
   endtask

   task automatic model_pixel(input int col, input int row, input logic [15:0] z, input logic [15:0] c);
      if (col == 0 && row == 0) begin
         m_crc = 8'h00;
         m_put(8'hA5); m_put(8'h5A); m_put(m_fc[15:8]); m_put(m_fc[7:0]);
         m_fc = m_fc + 16'd1;
      end
      m_put(z[15:8]); m_put(z[7:0]); m_put(c[15:8]); m_put(c[7:0]);
`ifdef DEPTH_PACKET_CRC_EN
      if (col == W - 1 && row == H - 1) q.push_back(m_crc);
`endif
   endtask

   // Output monitor: checks accepted bytes in order and stability under backpressure.
   logic       stall_v = 0;
   logic [7:0] stall_b = 0;
   int cyc = 0, n_acc = 0, t_last = 0, t_mark = 0, mark = -1;

   always @(negedge clk_i) begin
      cyc++;
      if (rst_i) stall_v = 1'b0;
      else begin
         if (stall_v) begin
            chk("hold_valid", byte_valid_o, 1);
            chk("hold_byte", byte_o, stall_b);
         end
         if (byte_valid_o && byte_ready_i) begin
            chk("byte_expected", q.size() != 0, 1);
            if (q.size() != 0) chk("byte", byte_o, q.pop_front());
            n_acc++;
            t_last = cyc;
            if (n_acc == mark) t_mark = cyc;
         end
         stall_v = byte_valid_o && !byte_ready_i;
         stall_b = byte_o;
      end
   end

   logic rnd_rdy  = 0;
   logic rdy_hold = 1;

   task automatic tick();
      @(posedge clk_i);
      #1;
      byte_ready_i = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_hold;
   endtask

   task automatic send(input int col, input int row, input logic [15:0] z, input logic [15:0] c,
                       input bit exp_drop);
      col_i = 16'(col); row_i = 16'(row); z_i = z; c_i = c; valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      if (col < W && row < H) begin
         if (exp_drop) begin
            m_drops++;
            m_ovf = 1'b1;
         end else model_pixel(col, row, z, c);
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && q.size() != 0; i++) tick();
      chk("drain", q.size(), 0);
      repeat (3) tick();
      chk("idle_after_drain", byte_valid_o, 0);
   endtask

   initial begin
      int  exp_len;
      bit  found;
      rst_i = 1; valid_i = 0; z_i = 0; c_i = 0; col_i = 0; row_i = 0; byte_ready_i = 1;
      repeat (3) tick();
      chk("rst_byte", byte_o, 0);
      chk("rst_valid", byte_valid_o, 0);
      chk("rst_fc", frame_count_o, 0);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_drops", pixels_dropped_o, 0);
      rst_i = 0;
      tick();

      // Two-pixel frame with ready held high: bytes must be back to back.
      mark = n_acc + 1;
      send(0, 0, 16'h1234, 16'h5678, 0);
      send(1, 0, 16'h9ABC, 16'hDEF0, 0);
      exp_len = q.size();
      wait_drain(100);
      chk("t1_span", t_last - t_mark, exp_len - 1);
      chk("t1_fc", frame_count_o, m_fc);

      // Backpressure on the ZLO byte.
      send(0, 0, 16'h1234, 16'h5678, 0);
      send(1, 0, 16'h9ABC, 16'hDEF0, 0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (byte_valid_o && byte_o == 8'h34) found = 1;
         else tick();
      end
      chk("t2_found", found, 1);
      rdy_hold = 0; byte_ready_i = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_stall_byte", byte_o, 8'h34);
         chk("t2_stall_valid", byte_valid_o, 1);
         tick();
      end
      rdy_hold = 1; byte_ready_i = 1;
      wait_drain(100);

      // Out-of-range pixel is discarded silently.
      send(2, 0, 16'h1111, 16'h2222, 0);
      repeat (8) tick();
      chk("t4_valid", byte_valid_o, 0);
      chk("t4_drops", pixels_dropped_o, m_drops);

      // Overflow: IDLE moves pixel 1 into the holding register, the FIFO takes 2..5,
      // and pixel 6 finds it full.
      rdy_hold = 0; byte_ready_i = 0;
      for (int i = 0; i < 6; i++) send(i % 2, 0, 16'(16'h0100 + i), 16'(16'h0200 + i), i == 5);
      repeat (4) tick();
      chk("t3_ovf", overflow_o, m_ovf);
      chk("t3_drops", pixels_dropped_o, m_drops);
      rdy_hold = 1;
      wait_drain(200);

      // Reset one cycle after the ZHI byte is accepted.
      send(0, 0, 16'hAAAA, 16'hBBBB, 0);
      for (int i = 0; i < 30 && q.size() != 3; i++) tick();
      chk("t5_reached_zhi", q.size(), 3);
      rst_i = 1; rdy_hold = 0; byte_ready_i = 0;
      tick();
      @(negedge clk_i);
      chk("t5_valid", byte_valid_o, 0);
      chk("t5_fc", frame_count_o, 0);
      chk("t5_ovf", overflow_o, 0);
      chk("t5_drops", pixels_dropped_o, 0);
      q.delete(); m_fc = 0; m_crc = 0; m_drops = 0; m_ovf = 0;
      rst_i = 0; rdy_hold = 1;
      tick();
      send(0, 0, 16'hCAFE, 16'hBEEF, 0);
      send(1, 0, 16'h0F0F, 16'hF0F0, 0);
      wait_drain(100);
      chk("t5_fc_after", frame_count_o, m_fc);

      // Randomized bursts, small enough that nothing overflows, random ready.
      rnd_rdy = 1;
      for (int b = 0; b < 25; b++) begin
         int len;
         len = $urandom_range(1, 4);
         for (int p = 0; p < len; p++) begin
            send($urandom_range(0, 2), ($urandom_range(0, 3) == 0) ? 1 : 0,
                 16'($urandom), 16'($urandom), 0);
            repeat ($urandom_range(0, 2)) tick();
         end
         wait_drain(400);
      end
      chk("rnd_fc", frame_count_o, m_fc);
      chk("rnd_drops", pixels_dropped_o, m_drops);
      chk("rnd_ovf", overflow_o, m_ovf);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
